// File: rtl/pulse_trig_pkg.sv
// Shared definitions for the pulse-pair trigger: FSM state encoding and
// the end-to-end latency from ADC input to trigger output.
package pulse_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUAL1  = 3'd1,
    ST_REARM1 = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_QUAL2  = 3'd4,
    ST_REARM2 = 3'd5,
    ST_HOLD   = 3'd6
  } state_e;

  // Input register, compare register and FSM/output register.
  localparam int LAT = 3;

endpackage

// File: rtl/pulse_discriminator.sv
// Compare stage of the trigger: polarity-aware threshold and hysteresis
// comparison plus a consecutive-sample width counter. All outputs are
// registered, so they describe the sample held in the input register one
// cycle earlier.
module pulse_discriminator
  import pulse_trig_pkg::*;
#(
  parameter int DW = 14,
  parameter int WW = 8
) (
  input  logic          adc_clk,
  input  logic          adc_rstn,
  input  logic [DW-1:0] sample_i,
  input  logic          polarity_i,
  input  logic [DW-1:0] threshold_i,
  input  logic [DW-1:0] hyst_i,
  input  logic [WW-1:0] min_width_i,
  output logic          beyond_o,
  output logic          released_o,
  output logic          qualified_o
);

  // Two guard bits: threshold (signed) plus or minus hysteresis (unsigned,
  // up to 2^DW-1) can reach beyond a DW+1 bit signed range.
  localparam int XW = DW + 2;

  logic signed [XW-1:0] s_x;
  logic signed [XW-1:0] thr_x;
  logic signed [XW-1:0] hyst_x;
  logic signed [XW-1:0] lo_x;
  logic signed [XW-1:0] hi_x;
  logic                 beyond_c;
  logic                 released_c;
  logic                 qual_c;

  logic [WW-1:0] run_q;
  logic [WW-1:0] run_d;
  logic [WW-1:0] mw_eff;
  logic [WW:0]   run_inc;

  logic beyond_q;
  logic released_q;
  logic qualified_q;

  assign s_x    = $signed({{2{sample_i[DW-1]}}, sample_i});
  assign thr_x  = $signed({{2{threshold_i[DW-1]}}, threshold_i});
  assign hyst_x = $signed({2'b00, hyst_i});
  assign lo_x   = thr_x - hyst_x;
  assign hi_x   = thr_x + hyst_x;

  assign beyond_c   = polarity_i ? (s_x < thr_x) : (s_x > thr_x);
  assign released_c = polarity_i ? (s_x >= hi_x) : (s_x <= lo_x);

  // A zero minimum width behaves like a width of one sample.
  assign mw_eff  = (min_width_i == '0) ? WW'(1) : min_width_i;
  assign run_inc = {1'b0, run_q} + (WW+1)'(1);

  // The run length saturates so a very long pulse can never wrap around
  // and qualify a second time.
  assign run_d  = !beyond_c ? '0 : (run_inc[WW] ? run_q : run_inc[WW-1:0]);
  assign qual_c = beyond_c && (run_inc == {1'b0, mw_eff});

  // Register the comparison results and the running width count.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      run_q       <= '0;
      beyond_q    <= 1'b0;
      released_q  <= 1'b0;
      qualified_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      beyond_q    <= beyond_c;
      released_q  <= released_c;
      qualified_q <= qual_c;
    end
  end

  assign beyond_o    = beyond_q;
  assign released_o  = released_q;
  assign qualified_o = qualified_q;

endmodule

// File: rtl/pulse_pair_trigger.sv
// Single-pulse / pulse-pair trigger for one ADC channel. Samples pass
// through an input register and the discriminator's compare register; the
// FSM register then produces strobes aligned with the delayed sample.
module pulse_pair_trigger
  import pulse_trig_pkg::*;
#(
  parameter int DW = 14,
  parameter int WW = 8,
  parameter int CW = 16
) (
  input  logic          adc_clk,
  input  logic          adc_rstn,
  input  logic [DW-1:0] adc_dat_i,
  input  logic          enable_i,
  input  logic          mode_i,
  input  logic          polarity_i,
  input  logic [DW-1:0] threshold_i,
  input  logic [DW-1:0] hyst_i,
  input  logic [WW-1:0] min_width_i,
  input  logic [CW-1:0] window_i,
  input  logic [CW-1:0] holdoff_i,
  output logic [DW-1:0] adc_dat_o,
  output logic          trig_o,
  output logic          first_o,
  output logic          timeout_o,
  output logic [CW-1:0] dt_o,
  output logic [31:0]   trig_cnt_o
);

  logic [DW-1:0] dly_q [LAT];

  logic beyond;
  logic released;
  logic qualified;

  state_e        state_q;
  logic          mode_q;
  logic [CW-1:0] dt_q;
  logic [CW-1:0] hold_q;
  logic          trig_q;
  logic          first_q;
  logic          timeout_q;
  logic [CW-1:0] dt_o_q;
  logic [31:0]   trig_cnt_q;

  logic [CW:0]   dt_inc;
  logic          dt_over;
  logic          sel_mode;

  // Sample delay line; stage 0 doubles as the discriminator input register.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= adc_dat_i;
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  pulse_discriminator #(
    .DW (DW),
    .WW (WW)
  ) u_disc (
    .adc_clk     (adc_clk),
    .adc_rstn    (adc_rstn),
    .sample_i    (dly_q[0]),
    .polarity_i  (polarity_i),
    .threshold_i (threshold_i),
    .hyst_i      (hyst_i),
    .min_width_i (min_width_i),
    .beyond_o    (beyond),
    .released_o  (released),
    .qualified_o (qualified)
  );

  // The interval is evaluated one bit wider so a full-scale window cannot
  // wrap into an apparent in-window value.
  assign dt_inc  = {1'b0, dt_q} + (CW+1)'(1);
  assign dt_over = dt_inc > {1'b0, window_i};

  // Mode is sampled live while idle and frozen once a sequence starts.
  assign sel_mode = (state_q == ST_IDLE) ? mode_i : mode_q;

  // Trigger FSM with interval/holdoff counters and registered strobes.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      dt_q       <= '0;
      hold_q     <= '0;
      trig_q     <= 1'b0;
      first_q    <= 1'b0;
      timeout_q  <= 1'b0;
      dt_o_q     <= '0;
      trig_cnt_q <= '0;
    end else begin
      trig_q    <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (state_q == ST_IDLE) mode_q <= mode_i;

      if (!enable_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_QUAL1: begin
            if (qualified) begin
              if (sel_mode) begin
                first_q <= 1'b1;
                dt_q    <= '0;
                state_q <= ST_REARM1;
              end else begin
                trig_q     <= 1'b1;
                trig_cnt_q <= trig_cnt_q + 32'd1;
                state_q    <= ST_REARM2;
              end
            end else if (state_q == ST_IDLE && beyond) begin
              state_q <= ST_QUAL1;
            end else if (state_q == ST_QUAL1 && released) begin
              state_q <= ST_IDLE;
            end
          end
          ST_REARM1: begin
            dt_q <= dt_inc[CW-1:0];
            if (dt_over) begin
              timeout_q <= 1'b1;
              state_q   <= ST_REARM2;
            end else if (released) begin
              state_q <= ST_WAIT2;
            end
          end
          ST_WAIT2, ST_QUAL2: begin
            dt_q <= dt_inc[CW-1:0];
            if (qualified && !dt_over) begin
              trig_q     <= 1'b1;
              trig_cnt_q <= trig_cnt_q + 32'd1;
              dt_o_q     <= dt_inc[CW-1:0];
              state_q    <= ST_REARM2;
            end else if (dt_over) begin
              timeout_q <= 1'b1;
              state_q   <= ST_REARM2;
            end else if (state_q == ST_WAIT2 && beyond) begin
              state_q <= ST_QUAL2;
            end else if (state_q == ST_QUAL2 && released) begin
              state_q <= ST_WAIT2;
            end
          end
          ST_REARM2: begin
            if (released) begin
              hold_q  <= '0;
              state_q <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (hold_q >= holdoff_i) state_q <= ST_IDLE;
            else hold_q <= hold_q + CW'(1);
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign adc_dat_o  = dly_q[LAT-1];
  assign trig_o     = trig_q;
  assign first_o    = first_q;
  assign timeout_o  = timeout_q;
  assign dt_o       = dt_o_q;
  assign trig_cnt_o = trig_cnt_q;

endmodule

// File: tb/tb_pulse_pair_trigger.sv
// Directed bench for pulse_pair_trigger: each expected strobe is queued
// when its qualifying sample is driven and checked when the DUT emits it.
module tb_pulse_pair_trigger;

  localparam logic [2:0] K_TRIG  = 3'b001;
  localparam logic [2:0] K_FIRST = 3'b010;
  localparam logic [2:0] K_TO    = 3'b100;

  logic        adc_clk;
  logic        adc_rstn;
  logic [13:0] adc_dat_i;
  logic        enable_i;
  logic        mode_i;
  logic        polarity_i;
  logic [13:0] threshold_i;
  logic [13:0] hyst_i;
  logic [7:0]  min_width_i;
  logic [15:0] window_i;
  logic [15:0] holdoff_i;
  logic [13:0] adc_dat_o;
  logic        trig_o;
  logic        first_o;
  logic        timeout_o;
  logic [15:0] dt_o;
  logic [31:0] trig_cnt_o;

  typedef struct {
    int          cyc;
    logic [2:0]  kind;
    logic [13:0] dat;
    logic [15:0] dt;
    logic [31:0] cnt;
  } ev_t;

  ev_t         sb[$];
  int          cyc = 0;
  int          drv_cyc = 0;
  int          vec = 0;
  int          miscmp = 0;
  logic [31:0] exp_cnt = 0;
  logic [15:0] last_dt = 0;

  pulse_pair_trigger #(.DW(14), .WW(8), .CW(16)) dut (
    .adc_clk     (adc_clk),
    .adc_rstn    (adc_rstn),
    .adc_dat_i   (adc_dat_i),
    .enable_i    (enable_i),
    .mode_i      (mode_i),
    .polarity_i  (polarity_i),
    .threshold_i (threshold_i),
    .hyst_i      (hyst_i),
    .min_width_i (min_width_i),
    .window_i    (window_i),
    .holdoff_i   (holdoff_i),
    .adc_dat_o   (adc_dat_o),
    .trig_o      (trig_o),
    .first_o     (first_o),
    .timeout_o   (timeout_o),
    .dt_o        (dt_o),
    .trig_cnt_o  (trig_cnt_o)
  );

  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  always @(posedge adc_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample per clock, applied 1 time unit after the rising edge.
  task automatic drive(input int v);
    @(posedge adc_clk);
    #1;
    adc_dat_i = 14'(v);
    drv_cyc   = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0);
  endtask

  // Strobe expected three edges after the sample is applied, with that
  // sample showing on adc_dat_o. new_dt < 0 means dt_o keeps its value.
  task automatic push(input logic [2:0] kind, input int v, input int new_dt);
    ev_t e;
    if (kind == K_TRIG) exp_cnt = exp_cnt + 32'd1;
    if (new_dt >= 0) last_dt = 16'(new_dt);
    e.cyc  = drv_cyc + 3;
    e.kind = kind;
    e.dat  = 14'(v);
    e.dt   = last_dt;
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic pulse(input int v, input int len, input int qual_at,
                       input logic [2:0] kind, input int new_dt);
    for (int i = 1; i <= len; i++) begin
      drive(v);
      if (i == qual_at && kind != 3'b000) push(kind, v, new_dt);
    end
  endtask

  initial begin
    ev_t        ev;
    logic [2:0] obs;

    adc_rstn    = 1'b0;
    adc_dat_i   = '0;
    enable_i    = 1'b1;
    mode_i      = 1'b0;
    polarity_i  = 1'b1;
    threshold_i = 14'(-100);
    hyst_i      = 14'd20;
    min_width_i = 8'd3;
    window_i    = 16'd1000;
    holdoff_i   = 16'd5;

    // Scoreboard monitor, sampling on the falling edge.
    fork
      forever begin
        @(negedge adc_clk);
        if (adc_rstn) begin
          obs = {timeout_o, first_o, trig_o};
          if (sb.size() != 0 && sb[0].cyc < cyc) begin
            ev = sb.pop_front();
            chk("missing_strobe_due_cycle", 64'(ev.cyc), 64'(cyc));
          end
          if (obs != 3'b000) begin
            if (sb.size() == 0) begin
              chk("unexpected_strobe", 64'(obs), 64'd0);
            end else begin
              ev = sb.pop_front();
              $display("event cyc=%0d kind=%b dat=%0d dt=%0d cnt=%0d", cyc, obs,
                       $signed(adc_dat_o), dt_o, trig_cnt_o);
              chk("strobe_cycle", 64'(cyc), 64'(ev.cyc));
              chk("strobe_kind", 64'(obs), 64'(ev.kind));
              chk("aligned_sample", 64'(adc_dat_o), 64'(ev.dat));
              chk("dt_o", 64'(dt_o), 64'(ev.dt));
              chk("trig_cnt_o", 64'(trig_cnt_o), 64'(ev.cnt));
            end
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge adc_clk);
    chk("rst_trig", 64'(trig_o), 64'd0);
    chk("rst_first", 64'(first_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_dt", 64'(dt_o), 64'd0);
    chk("rst_cnt", 64'(trig_cnt_o), 64'd0);
    chk("rst_dat", 64'(adc_dat_o), 64'd0);
    @(posedge adc_clk);
    #1 adc_rstn = 1'b1;
    idle(10);

    // 1. Single mode, 3-sample negative pulse triggers on its third sample.
    pulse(-500, 3, 3, K_TRIG, -1);
    idle(20);
    chk("cnt_after_first_pulse", 64'(trig_cnt_o), 64'd1);

    // 2. Too-short pulse is rejected; a long pulse triggers only once.
    pulse(-500, 2, 0, 3'b000, -1);
    idle(20);
    pulse(-500, 50, 3, K_TRIG, -1);
    idle(20);

    // 3. Hysteresis: chatter around threshold cannot retrigger until >= -80.
    min_width_i = 8'd1;
    pulse(-500, 1, 1, K_TRIG, -1);
    for (int i = 0; i < 20; i++) begin
      drive(-95);
      drive(-105);
    end
    pulse(-80, 10, 0, 3'b000, -1);
    pulse(-105, 1, 1, K_TRIG, -1);
    idle(20);
    min_width_i = 8'd3;

    // 4. Pair mode, pulses 400 ticks apart.
    mode_i = 1'b1;
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(397);
    pulse(-500, 3, 3, K_TRIG, 400);
    idle(20);

    // 5. Second pulse one tick past the window times out; exactly at it triggers.
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(998);
    pulse(-500, 3, 3, K_TO, -1);
    idle(20);
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(997);
    pulse(-500, 3, 3, K_TRIG, 1000);
    idle(20);

    // 6a. Long holdoff swallows a pulse arriving during HOLD.
    mode_i    = 1'b0;
    holdoff_i = 16'd200;
    pulse(-500, 3, 3, K_TRIG, -1);
    idle(47);
    pulse(-500, 3, 0, 3'b000, -1);
    idle(200);
    pulse(-500, 3, 3, K_TRIG, -1);
    idle(210);
    holdoff_i = 16'd5;

    // 6b. Dropping enable mid-WAIT2 abandons the pair silently.
    mode_i = 1'b1;
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(20);
    enable_i = 1'b0;
    idle(1);
    enable_i = 1'b1;
    idle(10);
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(97);
    pulse(-500, 3, 3, K_TRIG, 100);
    idle(20);

    // 6c. Reset mid-WAIT2 clears everything; the next pulse is a first pulse.
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(30);
    adc_rstn = 1'b0;
    exp_cnt  = 32'd0;
    last_dt  = 16'd0;
    repeat (2) @(negedge adc_clk);
    chk("midrst_cnt", 64'(trig_cnt_o), 64'd0);
    chk("midrst_dt", 64'(dt_o), 64'd0);
    chk("midrst_first", 64'(first_o), 64'd0);
    chk("midrst_dat", 64'(adc_dat_o), 64'd0);
    @(posedge adc_clk);
    #1 adc_rstn = 1'b1;
    idle(5);
    pulse(-500, 3, 3, K_FIRST, -1);
    idle(47);
    pulse(-500, 3, 3, K_TRIG, 50);
    idle(30);

    chk("queue_drained", 64'(sb.size()), 64'd0);
    chk("final_cnt", 64'(trig_cnt_o), 64'(exp_cnt));
    chk("final_dt_held", 64'(dt_o), 64'(last_dt));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
